// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux arbiter and its helpers.
package mux_rr_arbiter_pkg;

    // Two-state ownership FSM: nobody owns the mux, or exactly one owner does.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N        = 8;
    localparam int DEF_SEL_W    = 3;
    localparam int DEF_MAX_HOLD = 16;

    // Hold counter width; a disabled timeout (0) still needs a 1-bit counter.
    function automatic int holdWidth(input int maxHold);
        return (maxHold < 1) ? 1 : $clog2(maxHold + 1);
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// Plain 8:1 data mux driven by the arbiter's select output.
module mux_8x1 #(
    parameter int W = 8
) (
    input  logic [8*W-1:0] i_data,
    input  logic [2:0]     i_sel,
    output logic [W-1:0]   o_y
);

    logic [W-1:0] w_lane [8];

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_lane
            assign w_lane[g] = i_data[g*W +: W];
        end
    endgenerate

    assign o_y = w_lane[i_sel];

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: finds the first set request bit
// starting at the pointer and wrapping from N-1 back to 0.
module rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_win_idx
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    // Walk the requests in priority order; N is a power of two so the index wraps naturally.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = i_ptr;
        o_win_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = i_ptr + SEL_W'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found   = 1'b1;
                o_win_idx = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that hands one shared N:1 mux to one requester at a time.
// Ownership ends when the owner drops its request or after MAX_HOLD cycles,
// and every release leaves one idle cycle before the next owner is picked.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int SEL_W    = $clog2(N),
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = holdWidth(MAX_HOLD)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_gnt_valid,
    output logic             o_timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
    localparam logic [N-1:0]      GRANT_ONE  = N'(1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     w_grant_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             r_gnt_valid;
    logic             w_gnt_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic             w_any;
    logic [SEL_W-1:0] w_win_idx;
    logic             w_owner_req;
    logic             w_hold_hit;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_any     (w_any),
        .o_win_idx (w_win_idx)
    );

    // The registered select always names the current owner while in GRANT.
    assign w_owner_req = i_req[r_sel];
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIMIT);

    // Next-state and next-output decisions for the ownership FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_grant_nxt     = r_grant;
        w_sel_nxt       = r_sel;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_en && w_any) begin
                    w_state_nxt     = ST_GRANT;
                    w_grant_nxt     = GRANT_ONE << w_win_idx;
                    w_sel_nxt       = w_win_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = HOLD_W'(1);
                end else begin
                    w_grant_nxt     = '0;
                    w_gnt_valid_nxt = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req || w_hold_hit) begin
                    // A dropped request wins over a coincident timeout, so the pulse
                    // only fires when the owner was still asking for the mux.
                    w_state_nxt     = ST_IDLE;
                    w_grant_nxt     = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_sel + SEL_W'(1);
                    w_hold_nxt      = '0;
                    w_timeout_nxt   = w_owner_req;
                end else if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_grant_nxt     = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and all outputs update together; reset clears them at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_grant     <= '0;
            r_sel       <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_grant     <= w_grant_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign o_grant     = r_grant;
    assign o_sel       = r_sel;
    assign o_gnt_valid = r_gnt_valid;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter driving a mux_8x1: directed vector table with
// hand-derived expectations, a mid-grant reset, then a random run against a
// small behavioural model with a waiting-time bound.
module tb_mux_rr_arbiter;

    localparam int N          = 8;
    localparam int MAX_HOLD   = 4;
    localparam int WAIT_BOUND = (N - 1) * (MAX_HOLD + 1);

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       timeout;
    } vec_t;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       timeout;
    } expOut_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        en;
    logic [7:0]  req;
    logic [7:0]  grant;
    logic [2:0]  sel;
    logic        gntValid;
    logic        timeoutPulse;
    logic [63:0] muxData;
    logic [7:0]  muxY;
    logic [7:0]  laneByte [8];

    vec_t    vecs[$];
    expOut_t scoreboard[$];
    int      checks   = 0;
    int      failures = 0;

    logic       trackWaits = 1'b0;
    logic [7:0] prevReq    = '0;
    logic [7:0] waitActive = '0;
    int         waitCnt [8];
    int         maxWait    = 0;

    logic       mState;
    int         mPtr;
    int         mHold;
    logic [7:0] mGrant;
    logic [2:0] mSel;
    logic       mValid;
    logic       mTo;

    mux_rr_arbiter #(
        .N        (N),
        .SEL_W    (3),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_en        (en),
        .i_req       (req),
        .o_grant     (grant),
        .o_sel       (sel),
        .o_gnt_valid (gntValid),
        .o_timeout   (timeoutPulse)
    );

    mux_8x1 #(.W(8)) mux (
        .i_data (muxData),
        .i_sel  (sel),
        .o_y    (muxY)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic e, input logic [7:0] r, input logic [7:0] g,
                          input logic [2:0] s, input logic v, input logic t);
        vec_t x;
        x = '{e, r, g, s, v, t};
        vecs.push_back(x);
    endtask

    task automatic updateWaits();
        for (int i = 0; i < N; i++) begin
            if (!req[i] || grant[i]) begin
                waitActive[i] = 1'b0;
                waitCnt[i]    = 0;
            end else begin
                if (!prevReq[i]) waitActive[i] = 1'b1;
                if (waitActive[i]) begin
                    waitCnt[i]++;
                    if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
                end
            end
        end
        prevReq = req;
    endtask

    // Drive at the falling edge, expect the result just after the next rising edge.
    task automatic applyStimulus(input logic enV, input logic [7:0] reqV, input expOut_t exp);
        expOut_t got;
        en  = enV;
        req = reqV;
        scoreboard.push_back(exp);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty: actual=0 required=1");
        end else begin
            got = scoreboard.pop_front();
            checkOutput("grant", 32'(grant), 32'(got.grant));
            checkOutput("sel", 32'(sel), 32'(got.sel));
            checkOutput("gnt_valid", 32'(gntValid), 32'(got.valid));
            checkOutput("timeout", 32'(timeoutPulse), 32'(got.timeout));
            checkOutput("mux_y", 32'(muxY), 32'(laneByte[got.sel]));
        end
        checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        if (gntValid) checkOutput("grant_matches_sel", 32'(grant), 32'(8'(1) << sel));
        if (trackWaits) updateWaits();
        @(negedge clk);
    endtask

    task automatic modelReset();
        mState = 1'b0;
        mPtr   = 0;
        mHold  = 0;
        mGrant = '0;
        mSel   = '0;
        mValid = 1'b0;
        mTo    = 1'b0;
    endtask

    // Behavioural view of one clock edge of the arbiter.
    task automatic modelStep(input logic enV, input logic [7:0] reqV);
        int winner;
        mTo = 1'b0;
        if (!mState) begin
            winner = -1;
            for (int k = 0; k < N; k++) begin
                if (winner < 0 && reqV[(mPtr + k) % N]) winner = (mPtr + k) % N;
            end
            if (enV && winner >= 0) begin
                mState = 1'b1;
                mGrant = 8'(1) << winner;
                mSel   = 3'(winner);
                mValid = 1'b1;
                mHold  = 1;
            end else begin
                mGrant = '0;
                mValid = 1'b0;
            end
        end else begin
            if (!reqV[mSel] || mHold == MAX_HOLD) begin
                mTo    = reqV[mSel];
                mState = 1'b0;
                mGrant = '0;
                mValid = 1'b0;
                mPtr   = (int'(mSel) + 1) % N;
                mHold  = 0;
            end else begin
                mHold++;
            end
        end
    endtask

    initial begin
        expOut_t    exp;
        logic [7:0] nextReq;

        for (int i = 0; i < N; i++) begin
            laneByte[i]          = 8'(8'h5A + 37 * i);
            muxData[i*8 +: 8]    = laneByte[i];
            waitCnt[i]           = 0;
        end

        // Reset and single requester.
        addVec(1, 8'hFF, 8'h01, 3'd0, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'h20, 8'h20, 3'd5, 1, 0);
        addVec(1, 8'h20, 8'h20, 3'd5, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd5, 0, 0);
        addVec(1, 8'h60, 8'h40, 3'd6, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd6, 0, 0);
        // Wrap: pointer at 7, requests 6 and 0 -> 0 wins.
        addVec(1, 8'h41, 8'h01, 3'd0, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'h80, 8'h80, 3'd7, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd7, 0, 0);
        // Rotation 0,4,7,0,4,7 with bubbles.
        for (int rep = 0; rep < 2; rep++) begin
            addVec(1, 8'h91, 8'h01, 3'd0, 1, 0);
            addVec(1, 8'h91, 8'h01, 3'd0, 1, 0);
            addVec(1, 8'h90, 8'h00, 3'd0, 0, 0);
            addVec(1, 8'h91, 8'h10, 3'd4, 1, 0);
            addVec(1, 8'h91, 8'h10, 3'd4, 1, 0);
            addVec(1, 8'h81, 8'h00, 3'd4, 0, 0);
            addVec(1, 8'h91, 8'h80, 3'd7, 1, 0);
            addVec(1, 8'h91, 8'h80, 3'd7, 1, 0);
            addVec(1, (rep == 0) ? 8'h11 : 8'h00, 8'h00, 3'd7, 0, 0);
        end
        // Timeout: 2 for four cycles, pulse, 3 for four cycles, pulse, then 2.
        for (int i = 0; i < 4; i++) addVec(1, 8'h0C, 8'h04, 3'd2, 1, 0);
        addVec(1, 8'h0C, 8'h00, 3'd2, 0, 1);
        for (int i = 0; i < 4; i++) addVec(1, 8'h0C, 8'h08, 3'd3, 1, 0);
        addVec(1, 8'h0C, 8'h00, 3'd3, 0, 1);
        addVec(1, 8'h0C, 8'h04, 3'd2, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd2, 0, 0);
        // Request drop on the same edge as the hold limit: no pulse.
        for (int i = 0; i < 4; i++) addVec(1, 8'h0C, 8'h08, 3'd3, 1, 0);
        addVec(1, 8'h04, 8'h00, 3'd3, 0, 0);
        // Sole requester wins again right after its own timeout.
        for (int i = 0; i < 4; i++) addVec(1, 8'h08, 8'h08, 3'd3, 1, 0);
        addVec(1, 8'h08, 8'h00, 3'd3, 0, 1);
        addVec(1, 8'h08, 8'h08, 3'd3, 1, 0);
        addVec(1, 8'h00, 8'h00, 3'd3, 0, 0);
        // Enable low during a grant only blocks the next pick.
        addVec(1, 8'h08, 8'h08, 3'd3, 1, 0);
        addVec(0, 8'h08, 8'h08, 3'd3, 1, 0);
        addVec(0, 8'h0C, 8'h08, 3'd3, 1, 0);
        addVec(0, 8'h04, 8'h00, 3'd3, 0, 0);
        addVec(0, 8'h04, 8'h00, 3'd3, 0, 0);
        addVec(0, 8'hFF, 8'h00, 3'd3, 0, 0);
        addVec(1, 8'h04, 8'h04, 3'd2, 1, 0);

        $display("[TB] reset phase");
        rstN = 1'b0;
        en   = 1'b1;
        req  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_grant", 32'(grant), 32'h0);
        checkOutput("reset_sel", 32'(sel), 32'h0);
        checkOutput("reset_gnt_valid", 32'(gntValid), 32'h0);
        checkOutput("reset_timeout", 32'(timeoutPulse), 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] directed vectors: %0d", vecs.size());
        foreach (vecs[i]) begin
            exp = '{vecs[i].grant, vecs[i].sel, vecs[i].valid, vecs[i].timeout};
            applyStimulus(vecs[i].en, vecs[i].req, exp);
        end

        // Owner 2 holds the mux here; reset must clear everything without an edge.
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_grant", 32'(grant), 32'h0);
        checkOutput("async_rst_sel", 32'(sel), 32'h0);
        checkOutput("async_rst_gnt_valid", 32'(gntValid), 32'h0);
        checkOutput("async_rst_timeout", 32'(timeoutPulse), 32'h0);
        req = 8'h00;
        en  = 1'b1;
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] random phase");
        modelReset();
        prevReq    = '0;
        trackWaits = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            nextReq = req;
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) nextReq[i] = 1'b1;
                end else if (mGrant[i] && $urandom_range(2) == 0) begin
                    nextReq[i] = 1'b0;
                end
            end
            modelStep(1'b1, nextReq);
            exp = '{mGrant, mSel, mValid, mTo};
            applyStimulus(1'b1, nextReq, exp);
        end
        trackWaits = 1'b0;
        checkOutput("max_wait_within_bound", 32'(maxWait <= WAIT_BOUND), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
